pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The module SHALL have a single clock; reset is synchronous and active-high.
REQ-002 Parameter: MAC_CYCLES, default 4, number of ID-stall cycles a MAC instruction occupies (legal 2..15).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 id_valid  in  1  ID stage holds a valid instruction.
REQ-006 id_inst_type  in  5  Inst[6:2] of the ID instruction.
REQ-007 id_rs1, id_rs2  in  5 each  source register fields, Inst[19:15] and Inst[24:20].
REQ-008 ex_valid  in  1  EX stage holds a valid instruction.
REQ-009 ex_is_load  in  1  EX instruction is LOAD type.
REQ-010 ex_rd  in  5  EX destination register.
REQ-011 branch_taken  in  1  EX branch resolved taken this cycle.
REQ-012 stall_if, stall_id  out  1 each  hold the PC and IF/ID registers.
REQ-013 bubble_ex  out  1  insert a NOP into ID/EX this cycle.
REQ-014 flush_id  out  1  invalidate the IF/ID contents at the next edge.
REQ-015 mac_start  out  1  one-cycle start pulse to the MAC unit.
REQ-016 mac_busy  out  1  high while in state MAC_BUSY.
REQ-017 stall_count  out  16  saturating count of cycles with stall_id high.

Function
REQ-018 The FSM SHALL have exactly two states: RUN and MAC_BUSY.
REQ-019 Outputs stall_if, stall_id, bubble_ex, flush_id and mac_start SHALL be combinational functions of state and inputs.
REQ-020 Hazard definition: load_use = ex_valid & ex_is_load & ex_rd!=0 & id_valid & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)).
REQ-021 uses_rs1 SHALL be true for types 00100, 01100, 00000, 01000, 11000 and 11111.
REQ-022 uses_rs2 SHALL be true for types 01100, 01000, 11000 and 11111; any other type uses neither register.
REQ-023 RUN with branch_taken: flush_id=1 and bubble_ex=1, no stall, no mac_start, state stays RUN. Branch_taken has top priority.
REQ-024 RUN with load_use and no branch_taken: stall_if=stall_id=bubble_ex=1 for that cycle only, state stays RUN.
REQ-025 RUN with id_valid & id_inst_type==11111, no load_use and no branch_taken:
- mac_start=1 and stall_if=stall_id=1 that cycle;
- counter loads MAC_CYCLES-2;
- next state MAC_BUSY.
REQ-026 MAC_BUSY: stall_if=stall_id=bubble_ex=1. The counter decrements each cycle; when it reads 0, next state is RUN.
REQ-027 Total stall for one MAC SHALL be exactly MAC_CYCLES cycles, counting the mac_start cycle.
REQ-028 branch_taken and load_use SHALL be ignored in MAC_BUSY; EX holds bubbles there.
REQ-029 A MAC whose ID cycle coincides with load_use SHALL stall one cycle first, then start.
REQ-030 Back-to-back MACs: the second MAC is evaluated in the first RUN cycle after MAC_BUSY.
REQ-031 stall_count SHALL increment on each clock edge where stall_id=1, and saturate at 16'hFFFF.

Reset
REQ-032 rst SHALL set state=RUN, counter=0 and stall_count=0.
REQ-033 rst asserted mid-MAC SHALL abort it: no further stall from the next cycle onward.
REQ-034 While rst is high, all combinational outputs SHALL be forced to 0.

Structure
REQ-035 Opcode-type constants (IMMEDIATE 00100, REGISTER_REGISTER 01100, LOAD 00000, STORE 01000, BRANCH 11000, MAC 11111) and the state encoding SHALL live in the shared package used by the decode stage.
REQ-036 The combinational sub-module hazard_detect SHALL compute load_use (REQ-020..022); the FSM, counter and stall_count stay in pipe_ctrl.

Verification
REQ-037 Load-use: ex_is_load=1, ex_rd=5; ID holds RR type with rs2=5 -> stall_id=bubble_ex=1 for 1 cycle, stall_count=1.
REQ-038 No false hazard: the same case with ex_rd=0, or with IMMEDIATE type and rs2=5 -> no stall.
REQ-039 MAC with MAC_CYCLES=4: id_inst_type=11111 -> mac_start for 1 cycle, stall_id high for exactly 4 cycles, mac_busy for 3, stall_count=4.
REQ-040 Priority: branch_taken and load_use together with a MAC in ID -> flush_id=1, bubble_ex=1, no stall, no mac_start.
REQ-041 Reset in the 2nd MAC_BUSY cycle -> the next cycle is RUN with all outputs 0 and stall_count=0.
REQ-042 Saturation: force 65540 stall cycles -> stall_count holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared decode constants for the pipeline controller: opcode types, FSM
// state encoding and the register-usage helpers used by hazard detection.
package pipe_ctrl_pkg;

   localparam logic [4:0] TYPE_IMMEDIATE         = 5'b00100;
   localparam logic [4:0] TYPE_REGISTER_REGISTER = 5'b01100;
   localparam logic [4:0] TYPE_LOAD              = 5'b00000;
   localparam logic [4:0] TYPE_STORE             = 5'b01000;
   localparam logic [4:0] TYPE_BRANCH            = 5'b11000;
   localparam logic [4:0] TYPE_MAC               = 5'b11111;

   localparam logic STATE_RUN      = 1'b0;
   localparam logic STATE_MAC_BUSY = 1'b1;

   localparam int MAC_CNT_W = 4;

   function automatic logic uses_rs1(input logic [4:0] inst_type);
      return (inst_type == TYPE_IMMEDIATE) || (inst_type == TYPE_REGISTER_REGISTER) ||
             (inst_type == TYPE_LOAD)      || (inst_type == TYPE_STORE) ||
             (inst_type == TYPE_BRANCH)    || (inst_type == TYPE_MAC);
   endfunction

   function automatic logic uses_rs2(input logic [4:0] inst_type);
      return (inst_type == TYPE_REGISTER_REGISTER) || (inst_type == TYPE_STORE) ||
             (inst_type == TYPE_BRANCH)            || (inst_type == TYPE_MAC);
   endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by
// the instruction currently in ID.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic       ex_valid,
   input  logic       ex_is_load,
   input  logic [4:0] ex_rd,
   input  logic       id_valid,
   input  logic [4:0] id_inst_type,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   output logic       load_use
);

   logic rs1_match;
   logic rs2_match;

   // x0 is hardwired to zero, so a load targeting it never creates a hazard
   always_comb begin
      rs1_match = uses_rs1(id_inst_type) && (id_rs1 == ex_rd);
      rs2_match = uses_rs2(id_inst_type) && (id_rs2 == ex_rd);
      load_use  = ex_valid && ex_is_load && (ex_rd != 5'd0) && id_valid &&
                  (rs1_match || rs2_match);
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: branch flush, load-use interlock and a
// multi-cycle MAC that holds ID for MAC_CYCLES cycles.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MAC_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  id_inst_type,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        ex_valid,
   input  logic        ex_is_load,
   input  logic [4:0]  ex_rd,
   input  logic        branch_taken,
   output logic        stall_if,
   output logic        stall_id,
   output logic        bubble_ex,
   output logic        flush_id,
   output logic        mac_start,
   output logic        mac_busy,
   output logic [15:0] stall_count
);

   // The start cycle counts as one stall and the counter's zero cycle another
   localparam logic [MAC_CNT_W-1:0] MAC_LOAD = MAC_CNT_W'(MAC_CYCLES - 2);

   logic                 state;
   logic                 state_next;
   logic [MAC_CNT_W-1:0] mac_cnt;
   logic [MAC_CNT_W-1:0] mac_cnt_next;
   logic                 load_use;

   hazard_detect u_hazard_detect (
      .ex_valid     (ex_valid),
      .ex_is_load   (ex_is_load),
      .ex_rd        (ex_rd),
      .id_valid     (id_valid),
      .id_inst_type (id_inst_type),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .load_use     (load_use)
   );

   always_comb begin
      stall_if     = 1'b0;
      stall_id     = 1'b0;
      bubble_ex    = 1'b0;
      flush_id     = 1'b0;
      mac_start    = 1'b0;
      state_next   = state;
      mac_cnt_next = mac_cnt;
      if (!rst) begin
         case (state)
            STATE_RUN: begin
               if (branch_taken) begin
                  flush_id  = 1'b1;
                  bubble_ex = 1'b1;
               end else if (load_use) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  bubble_ex = 1'b1;
               end else if (id_valid && (id_inst_type == TYPE_MAC)) begin
                  mac_start    = 1'b1;
                  stall_if     = 1'b1;
                  stall_id     = 1'b1;
                  mac_cnt_next = MAC_LOAD;
                  state_next   = STATE_MAC_BUSY;
               end
            end
            STATE_MAC_BUSY: begin
               stall_if  = 1'b1;
               stall_id  = 1'b1;
               bubble_ex = 1'b1;
               if (mac_cnt == '0) begin
                  state_next = STATE_RUN;
               end else begin
                  mac_cnt_next = mac_cnt - 1'b1;
               end
            end
            default: state_next = STATE_RUN;
         endcase
      end
   end

   assign mac_busy = !rst && (state == STATE_MAC_BUSY);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= STATE_RUN;
         mac_cnt     <= '0;
         stall_count <= '0;
      end else begin
         state   <= state_next;
         mac_cnt <= mac_cnt_next;
         if (stall_id && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with MAC_CYCLES = 4.
module tb_pipe_ctrl;

   localparam logic [4:0] T_IMM = 5'b00100;
   localparam logic [4:0] T_RR  = 5'b01100;
   localparam logic [4:0] T_MAC = 5'b11111;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_inst_type;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        ex_valid;
   logic        ex_is_load;
   logic [4:0]  ex_rd;
   logic        branch_taken;
   logic        stall_if;
   logic        stall_id;
   logic        bubble_ex;
   logic        flush_id;
   logic        mac_start;
   logic        mac_busy;
   logic [15:0] stall_count;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(.MAC_CYCLES(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_inst_type (id_inst_type),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .ex_valid     (ex_valid),
      .ex_is_load   (ex_is_load),
      .ex_rd        (ex_rd),
      .branch_taken (branch_taken),
      .stall_if     (stall_if),
      .stall_id     (stall_id),
      .bubble_ex    (bubble_ex),
      .flush_id     (flush_id),
      .mac_start    (mac_start),
      .mac_busy     (mac_busy),
      .stall_count  (stall_count)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic [4:0] itype, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic ev, input logic ld,
                                input logic [4:0] rd, input logic br);
      id_valid     = iv;
      id_inst_type = itype;
      id_rs1       = rs1;
      id_rs2       = rs2;
      ex_valid     = ev;
      ex_is_load   = ld;
      ex_rd        = rd;
      branch_taken = br;
      #1;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, T_RR, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      stepCycle();
      rst = 1'b0;
      #1;
   endtask

   int stall_n;
   int busy_n;
   int start_n;

   initial begin
      rst = 1'b1;
      applyStimulus(1'b1, T_MAC, 5'd1, 5'd2, 1'b1, 1'b1, 5'd1, 1'b1);
      checkOutput("rst_stall_id", 32'(stall_id), 32'd0);
      checkOutput("rst_flush_id", 32'(flush_id), 32'd0);
      checkOutput("rst_mac_start", 32'(mac_start), 32'd0);
      stepCycle();
      checkOutput("rst_stall_count", 32'(stall_count), 32'd0);
      checkOutput("rst_mac_busy", 32'(mac_busy), 32'd0);
      rst = 1'b0;

      // load-use through rs2
      applyStimulus(1'b1, T_RR, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0);
      checkOutput("lu_stall_if", 32'(stall_if), 32'd1);
      checkOutput("lu_stall_id", 32'(stall_id), 32'd1);
      checkOutput("lu_bubble_ex", 32'(bubble_ex), 32'd1);
      checkOutput("lu_flush_id", 32'(flush_id), 32'd0);
      stepCycle();
      applyStimulus(1'b1, T_RR, 5'd1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0);
      checkOutput("lu_release", 32'(stall_id), 32'd0);
      checkOutput("lu_stall_count", 32'(stall_count), 32'd1);

      // no false hazards
      applyStimulus(1'b1, T_RR, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
      checkOutput("rd0_no_stall", 32'(stall_id), 32'd0);
      applyStimulus(1'b1, T_IMM, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0);
      checkOutput("imm_rs2_no_stall", 32'(stall_id), 32'd0);
      applyStimulus(1'b1, T_IMM, 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0);
      checkOutput("imm_rs1_stall", 32'(stall_id), 32'd1);
      applyStimulus(1'b0, T_RR, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0);
      checkOutput("id_invalid_no_stall", 32'(stall_id), 32'd0);
      applyStimulus(1'b1, T_RR, 5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0);
      checkOutput("not_load_no_stall", 32'(stall_id), 32'd0);
      stepCycle();
      checkOutput("after_checks_count", 32'(stall_count), 32'd1);

      // branch alone, then branch + load-use + MAC
      applyStimulus(1'b1, T_RR, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1);
      checkOutput("br_flush_id", 32'(flush_id), 32'd1);
      checkOutput("br_bubble_ex", 32'(bubble_ex), 32'd1);
      applyStimulus(1'b1, T_MAC, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1);
      checkOutput("prio_flush_id", 32'(flush_id), 32'd1);
      checkOutput("prio_bubble_ex", 32'(bubble_ex), 32'd1);
      checkOutput("prio_stall_id", 32'(stall_id), 32'd0);
      checkOutput("prio_stall_if", 32'(stall_if), 32'd0);
      checkOutput("prio_mac_start", 32'(mac_start), 32'd0);
      stepCycle();
      checkOutput("prio_no_busy", 32'(mac_busy), 32'd0);

      // single MAC: 1 start cycle + 3 busy cycles
      doReset();
      applyStimulus(1'b1, T_MAC, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
      checkOutput("mac_start", 32'(mac_start), 32'd1);
      checkOutput("mac_start_stall", 32'(stall_id), 32'd1);
      checkOutput("mac_start_bubble", 32'(bubble_ex), 32'd0);
      checkOutput("mac_start_not_busy", 32'(mac_busy), 32'd0);
      stepCycle();
      applyStimulus(1'b0, T_RR, 5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1);
      checkOutput("busy_ignores_branch", 32'(flush_id), 32'd0);
      checkOutput("busy_stall_id", 32'(stall_id), 32'd1);
      checkOutput("busy_bubble_ex", 32'(bubble_ex), 32'd1);
      applyStimulus(1'b0, T_RR, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      stall_n = 1;
      busy_n  = 0;
      start_n = 1;
      for (int i = 0; i < 6; i++) begin
         if (stall_id) stall_n++;
         if (mac_busy) busy_n++;
         if (mac_start) start_n++;
         stepCycle();
      end
      checkOutput("mac_total_stall", 32'(stall_n), 32'd4);
      checkOutput("mac_busy_cycles", 32'(busy_n), 32'd3);
      checkOutput("mac_start_pulses", 32'(start_n), 32'd1);
      checkOutput("mac_stall_count", 32'(stall_count), 32'd4);

      // MAC coinciding with load-use waits one cycle
      applyStimulus(1'b1, T_MAC, 5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0);
      checkOutput("maclu_stall", 32'(stall_id), 32'd1);
      checkOutput("maclu_bubble", 32'(bubble_ex), 32'd1);
      checkOutput("maclu_no_start", 32'(mac_start), 32'd0);
      stepCycle();
      applyStimulus(1'b1, T_MAC, 5'd7, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
      checkOutput("maclu_start", 32'(mac_start), 32'd1);
      stepCycle();
      applyStimulus(1'b0, T_RR, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      checkOutput("maclu_busy", 32'(mac_busy), 32'd1);

      // reset in the second busy cycle aborts the MAC
      doReset();
      applyStimulus(1'b1, T_MAC, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
      stepCycle();
      applyStimulus(1'b0, T_RR, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      stepCycle();
      checkOutput("abort_pre_busy", 32'(mac_busy), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("abort_rst_stall", 32'(stall_id), 32'd0);
      checkOutput("abort_rst_bubble", 32'(bubble_ex), 32'd0);
      stepCycle();
      rst = 1'b0;
      #1;
      checkOutput("abort_stall_id", 32'(stall_id), 32'd0);
      checkOutput("abort_mac_busy", 32'(mac_busy), 32'd0);
      checkOutput("abort_stall_count", 32'(stall_count), 32'd0);

      // back-to-back MACs held in ID
      applyStimulus(1'b1, T_MAC, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
      checkOutput("b2b_first_start", 32'(mac_start), 32'd1);
      for (int i = 0; i < 3; i++) stepCycle();
      checkOutput("b2b_last_busy", 32'(mac_busy), 32'd1);
      checkOutput("b2b_no_restart", 32'(mac_start), 32'd0);
      stepCycle();
      checkOutput("b2b_second_start", 32'(mac_start), 32'd1);
      checkOutput("b2b_run_state", 32'(mac_busy), 32'd0);

      // saturation with a persistent load-use
      doReset();
      applyStimulus(1'b1, T_RR, 5'd9, 5'd1, 1'b1, 1'b1, 5'd9, 1'b0);
      for (int i = 0; i < 65540; i++) stepCycle();
      checkOutput("sat_stall_id", 32'(stall_id), 32'd1);
      checkOutput("sat_stall_count", 32'(stall_count), 32'h0000FFFF);
      stepCycle();
      checkOutput("sat_hold", 32'(stall_count), 32'h0000FFFF);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
